mmio_port_timer: RTL and testbench

//  Memory-mapped I/O peripheral directly downstream of the single-cycle MIPS core's data-bus stage.
//  - Consumes the ALU-computed address, store data and MemWrite/MemRead strobes.
//  - Drives the processor's 32-bit PortOut and samples the 8-bit PortIn.
//  - Adds a programmable down-counter timer and one interrupt line.
//  - Read data is returned in the same cycle, so the core muxes it in place of RAM data when Hit=1.

---
 rtl/mmio_port_timer_pkg.sv | 18 +
 rtl/mmio_port_timer_in_sync_edge.sv | 32 +++
 rtl/mmio_port_timer.sv | 88 ++++++++
 tb/tb_mmio_port_timer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_port_timer_pkg.sv
// mmio_port_timer_pkg: register map, bit indices and window span for the MMIO port/timer
package mmio_port_timer_pkg;
    typedef enum logic [2:0] {
        REG_PORT_OUT  = 3'd0,
        REG_PORT_IN   = 3'd1,
        REG_STATUS    = 3'd2,
        REG_TMR_LOAD  = 3'd3,
        REG_TMR_COUNT = 3'd4,
        REG_TMR_CTRL  = 3'd5
    } reg_e;
    localparam logic [4:0] WIN_LAST = 5'h14;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_AR      = 1;
    localparam int CTRL_IRQ_TMR = 2;
    localparam int CTRL_IRQ_IN  = 3;
    localparam int ST_IN_CHG    = 0;
    localparam int ST_TMR_EXP   = 1;
endpackage

// File: rtl/mmio_port_timer_in_sync_edge.sv
// mmio_port_timer_in_sync_edge: 2-flop synchronizer with previous-value change detect
module mmio_port_timer_in_sync_edge #(
    parameter int IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IN_WIDTH-1:0] port_in,
    output logic [IN_WIDTH-1:0] sync,
    output logic                chg
);
    logic [IN_WIDTH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    // shift the pipeline one stage per cycle
    always_comb begin
        sync1_d = port_in;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end
    // sync flops clear on reset so no spurious change is seen afterwards
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end
    assign sync = sync2_q;
    assign chg  = sync2_q != prev_q;
endmodule

// File: rtl/mmio_port_timer.sv
// mmio_port_timer: memory-mapped output port, synchronized input port, down-counter timer and IRQ
module mmio_port_timer
    import mmio_port_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int          IN_WIDTH  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         Address,
    input  logic [31:0]         WriteData,
    input  logic                MemWrite,
    input  logic                MemRead,
    input  logic [IN_WIDTH-1:0] PortIn,
    output logic [31:0]         ReadData,
    output logic                Hit,
    output logic [31:0]         PortOut,
    output logic                IRQ
);
    logic [IN_WIDTH-1:0] in_sync;
    logic                in_chg;
    logic [31:0]         out_q, out_d, load_q, load_d, count_q, count_d;
    logic [3:0]          ctrl_q, ctrl_d;
    logic [1:0]          status_q, status_d, w1c;
    logic                irq_q, irq_d, we, en, exp;
    reg_e                sel;

    mmio_port_timer_in_sync_edge #(.IN_WIDTH(IN_WIDTH)) u_sync (
        .clk    (clk),
        .reset  (reset),
        .port_in(PortIn),
        .sync   (in_sync),
        .chg    (in_chg)
    );

    // address decode and same-cycle read mux
    always_comb begin
        Hit = (Address[31:5] == BASE_ADDR[31:5]) && (Address[1:0] == 2'b00) && (Address[4:0] <= WIN_LAST);
        sel = reg_e'(Address[4:2]);
        we  = Hit && MemWrite;
        ReadData = !(Hit && MemRead)   ? 32'd0 :
                   sel == REG_PORT_OUT  ? out_q :
                   sel == REG_PORT_IN   ? 32'(in_sync) :
                   sel == REG_STATUS    ? 32'(status_q) :
                   sel == REG_TMR_LOAD  ? load_q :
                   sel == REG_TMR_COUNT ? count_q :
                   32'(ctrl_q);
    end

    // next-state for registers, timer, sticky flags and IRQ; expiry always uses the current CTRL
    always_comb begin
        en      = ctrl_q[CTRL_EN];
        exp     = en && count_q == 32'd1;
        out_d   = (we && sel == REG_PORT_OUT) ? WriteData : out_q;
        load_d  = (we && sel == REG_TMR_LOAD) ? WriteData : load_q;
        ctrl_d  = (we && sel == REG_TMR_CTRL) ? WriteData[3:0] : ctrl_q;
        count_d = (we && sel == REG_TMR_LOAD) ? WriteData :
                  !en                         ? count_q :
                  count_q > 32'd1             ? count_q - 32'd1 :
                  exp                         ? (ctrl_q[CTRL_AR] ? load_q : 32'd0) :
                  count_q;
        w1c      = (we && sel == REG_STATUS) ? WriteData[1:0] : 2'b00;
        status_d = (status_q & ~w1c) | {exp, in_chg};
        irq_d    = (status_q[ST_IN_CHG] & ctrl_q[CTRL_IRQ_IN]) | (status_q[ST_TMR_EXP] & ctrl_q[CTRL_IRQ_TMR]);
    end

    // state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            load_q   <= '0;
            count_q  <= '0;
            ctrl_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            out_q    <= out_d;
            load_q   <= load_d;
            count_q  <= count_d;
            ctrl_q   <= ctrl_d;
            status_q <= status_d;
            irq_q    <= irq_d;
        end
    end

    assign PortOut = out_q;
    assign IRQ     = irq_q;
endmodule

// File: tb/tb_mmio_port_timer.sv
// tb_mmio_port_timer: directed feature checks plus randomized run against a behavioural model
`timescale 1ns/1ps
module tb_mmio_port_timer;
    localparam logic [31:0] B = 32'hFFFF_0000;
    logic        clk = 1'b0, reset = 1'b0, MemWrite = 1'b0, MemRead = 1'b0, Hit, IRQ;
    logic [31:0] Address = '0, WriteData = '0, ReadData, PortOut;
    logic [7:0]  PortIn = '0;
    int n_chk = 0, n_fail = 0;

    mmio_port_timer dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
        .MemWrite(MemWrite), .MemRead(MemRead), .PortIn(PortIn),
        .ReadData(ReadData), .Hit(Hit), .PortOut(PortOut), .IRQ(IRQ)
    );

    always #10 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData = d; MemWrite = 1'b1; MemRead = 1'b0;
        tick();
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] r, output logic h);
        Address = a; MemRead = 1'b1;
        #1;
        r = ReadData; h = Hit;
        MemRead = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r; logic h;
        PortIn = '0; reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        n_chk++; if (PortOut !== 32'd0) begin n_fail++; $display("FAIL reset_portout: got %h want 0", PortOut); end
        n_chk++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", IRQ); end
        rd(B + 32'h14, r, h);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL reset_ctrl_read: got %h want 0", r); end
        n_chk++; if (h !== 1'b1) begin n_fail++; $display("FAIL reset_ctrl_hit: got %b want 1", h); end
        rd(B + 32'h10, r, h);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL reset_count: got %h want 0", r); end
    endtask

    task automatic test_port_out();
        logic [31:0] r; logic h;
        wr(B, 32'hDEAD_BEEF);
        n_chk++; if (PortOut !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL portout_write: got %h want deadbeef", PortOut); end
        rd(B, r, h);
        n_chk++; if (r !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL portout_read: got %h want deadbeef", r); end
        wr(B + 32'h4, 32'h1234_5678);
        n_chk++; if (PortOut !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL portin_ro_write: got %h want deadbeef", PortOut); end
        rd(B + 32'h4, r, h);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL portin_ro_read: got %h want 0", r); end
    endtask

    task automatic test_addressing();
        logic [31:0] r; logic h;
        rd(B + 32'h18, r, h);
        n_chk++; if (h !== 1'b0 || r !== 32'd0) begin n_fail++; $display("FAIL addr_0x18: hit %b data %h want hit 0 data 0", h, r); end
        rd(B + 32'h2, r, h);
        n_chk++; if (h !== 1'b0 || r !== 32'd0) begin n_fail++; $display("FAIL addr_misaligned: hit %b data %h want hit 0 data 0", h, r); end
        Address = 32'h1001_0000; MemWrite = 1'b1; WriteData = 32'hFFFF_FFFF;
        #1;
        n_chk++; if (Hit !== 1'b0) begin n_fail++; $display("FAIL addr_ram_hit: got %b want 0", Hit); end
        tick(); MemWrite = 1'b0;
        n_chk++; if (PortOut !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL addr_ram_portout: got %h want deadbeef", PortOut); end
        rd(B + 32'hC, r, h);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL addr_ram_load: got %h want 0", r); end
        rd(B + 32'h14, r, h);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL addr_ram_ctrl: got %h want 0", r); end
    endtask

    task automatic test_port_in();
        logic [31:0] r; logic h;
        wr(B + 32'h14, 32'h8);
        PortIn = 8'h5A;
        tick(); tick();
        rd(B + 32'h8, r, h);
        n_chk++; if (r[0] !== 1'b0) begin n_fail++; $display("FAIL in_chg_early: got %b want 0", r[0]); end
        tick();
        rd(B + 32'h8, r, h);
        n_chk++; if (r[0] !== 1'b1) begin n_fail++; $display("FAIL in_chg_set: got %b want 1", r[0]); end
        rd(B + 32'h4, r, h);
        n_chk++; if (r !== 32'h5A) begin n_fail++; $display("FAIL port_in_read: got %h want 5a", r); end
        n_chk++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL in_irq_early: got %b want 0", IRQ); end
        tick();
        n_chk++; if (IRQ !== 1'b1) begin n_fail++; $display("FAIL in_irq_set: got %b want 1", IRQ); end
        wr(B + 32'h8, 32'h1);
        rd(B + 32'h8, r, h);
        n_chk++; if (r[0] !== 1'b0) begin n_fail++; $display("FAIL in_chg_w1c: got %b want 0", r[0]); end
        tick();
        n_chk++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL in_irq_clear: got %b want 0", IRQ); end
        wr(B + 32'h14, 32'h0);
    endtask

    task automatic run_timer(input logic [31:0] ctrl, input logic [31:0] s0, input logic [31:0] s1,
                             input logic [31:0] s2, input logic [31:0] s3, input logic [31:0] s4, input logic [31:0] s5);
        logic [31:0] r, seq [6]; logic h, seen;
        seq = '{s0, s1, s2, s3, s4, s5};
        wr(B + 32'h14, 32'h0);
        wr(B + 32'h8, 32'h3);
        wr(B + 32'hC, 32'd3);
        wr(B + 32'h14, ctrl);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rd(B + 32'h10, r, h);
            n_chk++; if (r !== seq[i]) begin n_fail++; $display("FAIL timer_count[%0d] ctrl %h: got %0d want %0d", i, ctrl, r, seq[i]); end
            rd(B + 32'h8, r, h);
            n_chk++; if (r[1] !== seen) begin n_fail++; $display("FAIL timer_exp[%0d] ctrl %h: got %b want %b", i, ctrl, r[1], seen); end
            if (seq[i] == 32'd1) seen = 1'b1;
            tick();
        end
    endtask

    task automatic test_timer_reload();
        run_timer(32'h3, 3, 2, 1, 3, 2, 1);
    endtask

    task automatic test_timer_oneshot();
        run_timer(32'h1, 3, 2, 1, 0, 0, 0);
    endtask

    task automatic test_w1c_collision();
        logic [31:0] r; logic h;
        wr(B + 32'h14, 32'h0);
        wr(B + 32'h8, 32'h3);
        wr(B + 32'hC, 32'd3);
        wr(B + 32'h14, 32'h1);
        tick(); tick();
        wr(B + 32'h8, 32'h2);
        rd(B + 32'h8, r, h);
        n_chk++; if (r[1] !== 1'b1) begin n_fail++; $display("FAIL w1c_vs_expiry: got %b want 1", r[1]); end
        rd(B + 32'h10, r, h);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL w1c_vs_expiry_count: got %0d want 0", r); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] r; logic h;
        wr(B + 32'h14, 32'h0);
        wr(B + 32'h8, 32'h3);
        wr(B + 32'hC, 32'd3);
        wr(B + 32'h14, 32'h7);
        tick();
        rd(B + 32'h10, r, h);
        n_chk++; if (r !== 32'd2) begin n_fail++; $display("FAIL midcount_pre: got %0d want 2", r); end
        reset = 1'b1; tick(); reset = 1'b0;
        rd(B + 32'h10, r, h);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL midcount_count: got %0d want 0", r); end
        rd(B + 32'h8, r, h);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL midcount_status: got %h want 0", r); end
        tick(); tick();
        rd(B + 32'h8, r, h);
        n_chk++; if (r !== 32'd0) begin n_fail++; $display("FAIL midcount_status_later: got %h want 0", r); end
        n_chk++; if (IRQ !== 1'b0) begin n_fail++; $display("FAIL midcount_irq: got %b want 0", IRQ); end
    endtask

    task automatic test_random();
        logic [31:0] m_out, m_load, m_cnt, r, a, d;
        logic [3:0]  m_ctrl;
        logic [1:0]  m_st, w1c;
        logic [7:0]  m_s1, m_s2, m_prev;
        logic        m_irq, h, chg, expd;
        int          op, off;
        PortIn = '0; reset = 1'b1; tick(); reset = 1'b0;
        m_out = 0; m_load = 0; m_cnt = 0; m_ctrl = 0; m_st = 0; m_s1 = 0; m_s2 = 0; m_prev = 0; m_irq = 0;
        for (int c = 0; c < 300; c++) begin
            op = int'($urandom_range(0, 4));
            off = int'($urandom_range(0, 5));
            d = (off == 3) ? $urandom_range(0, 4) : (off == 5) ? ($urandom | 32'h1) & {28'hFFFFFFF, 4'($urandom)} : $urandom;
            a = B + 32'(off * 4);
            if (op == 2) a = ($urandom_range(0, 1) == 1) ? B + 32'h18 + 32'($urandom_range(0, 1) * 4) : B + 32'(off * 4 + 1);
            if ($urandom_range(0, 3) == 0) PortIn = 8'($urandom);
            w1c = 2'b00;
            chg = m_s2 != m_prev;
            expd = m_ctrl[0] && m_cnt == 32'd1;
            m_irq = (m_st[0] & m_ctrl[3]) | (m_st[1] & m_ctrl[2]);
            if (m_ctrl[0]) m_cnt = (m_cnt == 32'd1) ? (m_ctrl[1] ? m_load : 32'd0) : (m_cnt == 32'd0 ? 32'd0 : m_cnt - 32'd1);
            if (op == 1 || op == 3) begin
                if (off == 0) m_out = d;
                if (off == 2) w1c = d[1:0];
                if (off == 3) begin m_load = d; m_cnt = d; end
                if (off == 5) m_ctrl = d[3:0];
            end
            m_st = (m_st & ~w1c) | {expd, chg};
            m_prev = m_s2; m_s2 = m_s1; m_s1 = PortIn;
            if (op == 0 || op == 4) tick();
            else wr(a, d);
            n_chk++; if (PortOut !== m_out) begin n_fail++; $display("FAIL rnd_portout c%0d: got %h want %h", c, PortOut, m_out); end
            n_chk++; if (IRQ !== m_irq) begin n_fail++; $display("FAIL rnd_irq c%0d: got %b want %b", c, IRQ, m_irq); end
            rd(B + 32'h10, r, h);
            n_chk++; if (r !== m_cnt) begin n_fail++; $display("FAIL rnd_count c%0d: got %0d want %0d", c, r, m_cnt); end
            rd(B + 32'h8, r, h);
            n_chk++; if (r !== 32'(m_st)) begin n_fail++; $display("FAIL rnd_status c%0d: got %h want %h", c, r, m_st); end
            rd(B + 32'h4, r, h);
            n_chk++; if (r !== 32'(m_s2)) begin n_fail++; $display("FAIL rnd_portin c%0d: got %h want %h", c, r, m_s2); end
            rd(B + 32'hC, r, h);
            n_chk++; if (r !== m_load) begin n_fail++; $display("FAIL rnd_load c%0d: got %h want %h", c, r, m_load); end
            rd(B + 32'h14, r, h);
            n_chk++; if (r !== 32'(m_ctrl)) begin n_fail++; $display("FAIL rnd_ctrl c%0d: got %h want %h", c, r, m_ctrl); end
        end
    endtask

    initial begin
        test_reset();
        test_port_out();
        test_addressing();
        test_port_in();
        test_timer_reload();
        test_timer_oneshot();
        test_w1c_collision();
        test_reset_midcount();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
